// File: rtl/ifid_skid_stage.sv
// IF/ID pipeline stage: valid/ready handshake with a main + skid entry,
// flush, a live sideband path and a saturating stall counter.
module ifid_skid_stage #(
    parameter int unsigned              DATA_W    = 32,
    parameter int unsigned              PC_W      = 32,
    parameter logic [DATA_W-1:0]        NOP_INSTR = 32'hFC000000,
    parameter int unsigned              SIDE_W    = 2,
    parameter int unsigned              LIVE_W    = 2,
    parameter int unsigned              CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [SIDE_W-1:0] in_side,
    input  logic [LIVE_W-1:0] live_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pc,
    output logic [SIDE_W-1:0] out_side,
    output logic [LIVE_W-1:0] live_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Occupancy encoded as {main_valid, skid_valid}
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_e;

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]   main_pc_q,    main_pc_d;
    logic [SIDE_W-1:0] main_side_q,  main_side_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]   skid_pc_q,    skid_pc_d;
    logic [SIDE_W-1:0] skid_side_q,  skid_side_d;
    logic [LIVE_W-1:0] live_q,       live_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

    state_e state;
    logic   accept;
    logic   drain;

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_instr = main_instr_q;
    assign out_pc    = main_pc_q;
    assign out_side  = main_side_q;
    assign live_out  = live_q;
    assign stall_cnt = stall_cnt_q;

    // Next-state for the main/skid entries, live sideband and stall counter
    always_comb begin
        state        = state_e'({main_valid_q, skid_valid_q});
        accept       = in_valid & ~skid_valid_q;
        drain        = main_valid_q & out_ready;

        main_valid_d = main_valid_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        main_side_d  = main_side_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_side_d  = skid_side_q;
        live_d       = live_in;
        stall_cnt_d  = stall_cnt_q;

        if (main_valid_q && !out_ready && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        if (flush) begin
            main_valid_d = 1'b0;
            main_instr_d = NOP_INSTR;
            main_pc_d    = '0;
            main_side_d  = '0;
            skid_valid_d = 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_valid_d = 1'b1;
                        main_instr_d = in_instr;
                        main_pc_d    = in_pc;
                        main_side_d  = in_side;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_instr_d = in_instr;
                        main_pc_d    = in_pc;
                        main_side_d  = in_side;
                    end else if (accept) begin
                        skid_valid_d = 1'b1;
                        skid_instr_d = in_instr;
                        skid_pc_d    = in_pc;
                        skid_side_d  = in_side;
                    end else if (drain) begin
                        main_valid_d = 1'b0;
                        main_instr_d = NOP_INSTR;
                        main_pc_d    = '0;
                        main_side_d  = '0;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        main_instr_d = skid_instr_q;
                        main_pc_d    = skid_pc_q;
                        main_side_d  = skid_side_q;
                        skid_valid_d = 1'b0;
                    end
                end
                default: begin
                    // Skid without main cannot arise; recover to EMPTY
                    skid_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_instr_q <= NOP_INSTR;
            main_pc_q    <= '0;
            main_side_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_side_q  <= '0;
            live_q       <= '0;
            stall_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            main_side_q  <= main_side_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_side_q  <= skid_side_d;
            live_q       <= live_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Directed self-checking bench for ifid_skid_stage (default and CNT_W=4).
module tb_ifid_skid_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready, in_ready4;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [1:0]  in_side;
    logic [1:0]  live_in;
    logic        flush;
    logic        out_valid, out_valid4;
    logic        out_ready;
    logic [31:0] out_instr, out_instr4;
    logic [31:0] out_pc, out_pc4;
    logic [1:0]  out_side, out_side4;
    logic [1:0]  live_out, live_out4;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt4;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOP = 32'hFC000000;

    always #5 clk = ~clk;

    ifid_skid_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_side(in_side), .live_in(live_in),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_side(out_side),
        .live_out(live_out), .stall_cnt(stall_cnt)
    );

    ifid_skid_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_instr(in_instr), .in_pc(in_pc), .in_side(in_side), .live_in(live_in),
        .flush(flush), .out_valid(out_valid4), .out_ready(out_ready),
        .out_instr(out_instr4), .out_pc(out_pc4), .out_side(out_side4),
        .live_out(live_out4), .stall_cnt(stall_cnt4)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [1:0] side);
        in_valid = v;
        in_pc    = pc;
        in_instr = 32'h1000_0000 | pc;
        in_side  = side;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; live_in = 2'b00;
        drive(1'b0, 32'h0, 2'b00);
        repeat (2) step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, NOP);
        chk("rst_out_pc",    out_pc, 0);
        chk("rst_out_side",  out_side, 0);
        chk("rst_in_ready",  in_ready, 1);
        chk("rst_live_out",  live_out, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        rst_n = 1'b1;

        // Streaming at full rate
        drive(1'b1, 32'h0, 2'b01); step();
        chk("s0_valid", out_valid, 1);
        chk("s0_pc", out_pc, 32'h0);
        chk("s0_side", out_side, 2'b01);
        drive(1'b1, 32'h4, 2'b10); step();
        chk("s1_pc", out_pc, 32'h4);
        chk("s1_instr", out_instr, 32'h1000_0004);
        chk("s1_in_ready", in_ready, 1);
        drive(1'b1, 32'h8, 2'b11); step();
        chk("s2_pc", out_pc, 32'h8);
        chk("s2_side", out_side, 2'b11);
        drive(1'b0, 32'h0, 2'b00); step();
        chk("s3_drained", out_valid, 0);
        chk("s3_instr_nop", out_instr, NOP);
        chk("s3_stall_cnt", stall_cnt, 0);

        // Stall absorption into skid
        drive(1'b1, 32'h10, 2'b01); step();
        chk("st_first_pc", out_pc, 32'h10);
        out_ready = 1'b0;
        drive(1'b1, 32'h14, 2'b10); step();
        chk("st1_pc", out_pc, 32'h10);
        chk("st1_in_ready", in_ready, 0);
        chk("st1_cnt", stall_cnt, 1);
        drive(1'b0, 32'h0, 2'b00);
        live_in = 2'b01; step();
        chk("st2_pc", out_pc, 32'h10);
        chk("st2_live", live_out, 2'b01);
        chk("st2_cnt", stall_cnt, 2);
        live_in = 2'b10; step();
        chk("st3_instr", out_instr, 32'h1000_0010);
        chk("st3_live", live_out, 2'b10);
        chk("st3_cnt", stall_cnt, 3);
        out_ready = 1'b1; step();
        chk("rel_pc", out_pc, 32'h14);
        chk("rel_side", out_side, 2'b10);
        chk("rel_valid", out_valid, 1);
        chk("rel_in_ready", in_ready, 1);
        chk("rel_cnt", stall_cnt, 3);
        step();
        chk("rel_done", out_valid, 0);

        // Flush while FULL with a coincident input
        drive(1'b1, 32'h30, 2'b00); step();
        out_ready = 1'b0;
        drive(1'b1, 32'h34, 2'b00); step();
        chk("fl_full", in_ready, 0);
        flush = 1'b1;
        drive(1'b1, 32'h20, 2'b11); step();
        chk("fl_valid", out_valid, 0);
        chk("fl_instr", out_instr, NOP);
        chk("fl_pc", out_pc, 0);
        chk("fl_in_ready", in_ready, 1);
        chk("fl_cnt", stall_cnt, 5);
        flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 32'h40, 2'b01); step();
        chk("post_fl_pc", out_pc, 32'h40);
        chk("post_fl_valid", out_valid, 1);
        drive(1'b0, 32'h0, 2'b00); step();
        chk("post_fl_drain", out_valid, 0);

        // Asynchronous reset while FULL
        drive(1'b1, 32'h50, 2'b00); step();
        out_ready = 1'b0;
        drive(1'b1, 32'h54, 2'b00); step();
        chk("ar_full", in_ready, 0);
        chk("ar_cnt_before", stall_cnt, 6);
        drive(1'b0, 32'h0, 2'b00);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_instr", out_instr, NOP);
        chk("ar_pc", out_pc, 0);
        chk("ar_in_ready", in_ready, 1);
        chk("ar_live", live_out, 0);
        chk("ar_cnt", stall_cnt, 0);
        chk("ar_cnt4", stall_cnt4, 0);
        step();
        rst_n = 1'b1;

        // Counter saturation on the CNT_W=4 instance
        out_ready = 1'b1;
        drive(1'b1, 32'h60, 2'b00); step();
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 2'b00);
        repeat (14) step();
        chk("sat_14", stall_cnt4, 4'hE);
        step();
        chk("sat_15", stall_cnt4, 4'hF);
        repeat (5) step();
        chk("sat_hold", stall_cnt4, 4'hF);
        chk("wide_20", stall_cnt, 20);
        chk("sat_out_pc", out_pc4, 32'h60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
